uart_rx_oversampled: RTL
========================

// Module: uart_rx_oversampled
// PURPOSE
//   UART receiver consuming the 16x-oversampling tick from the baud-rate mod-M counter.
//   Sits between the serial pin and the RX FIFO.
//   Recovers LSB-first 8N1-style frames, presents each received word with a one-cycle done
//   pulse, and flags framing errors.
// PARAMETERS
//   DBIT     8   data bits per frame (5..9)
//   SB_TICK  16  s_tick count for stop bit(s): 16 = 1 stop, 24 = 1.5, 32 = 2
// PORTS
//   clk           in   1     system clock; all logic on rising edge
//   reset         in   1     asynchronous, active-high reset
//   rx            in   1     serial input, idle high, asynchronous to clk
//   s_tick        in   1     1-clk strobe at 16x baud rate (baud counter max_tick)
//   dout          out  DBIT  last received word, LSB = first bit on line
//   rx_done_tick  out  1     1-clk pulse: dout/frame_err/parity_err valid
//   frame_err     out  1     stop bit sampled low on last frame
//   parity_err    out  1     parity mismatch on last frame (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, s=0, n=0, shift reg=0.
//     Synchroniser flops=1. dout=0, rx_done_tick=0, frame_err=0, parity_err=0.
//   Input sync: rx passes 2 flops (rx_s) before use; adds 2 clk latency to edge detection.
//   Counters: s (4b+, wide enough for SB_TICK-1) counts s_tick; n counts data bits (0..DBIT-1).
//   FSM IDLE/START/DATA/[PARITY]/STOP; s, n advance only on cycles with s_tick=1.
//   - IDLE:  rx_s==0 -> START, s=0. Otherwise stay. s_tick is ignored here.
//   - START: on s_tick, if s==7 (mid start bit):
//       rx_s==0 -> DATA, s=0, n=0.
//       rx_s==1 -> IDLE (glitch reject, no pulse, no flag change).
//     Otherwise s++.
//   - DATA:  on s_tick, if s==15: s=0, shreg={rx_s, shreg[DBIT-1:1]}.
//       If n==DBIT-1 -> PARITY (if enabled) else STOP; else n++.
//     Otherwise s++.
//   - STOP:  on s_tick, if s==SB_TICK-1:
//       dout<=shreg; frame_err<=~rx_s; rx_done_tick=1 for exactly that one clk; -> IDLE.
//     Otherwise s++.
//   - Sampling point is mid-bit (8 ticks after detected start edge, then every 16).
//   - dout, frame_err, parity_err are registered and hold until the next completed frame.
//     An aborted frame (glitch reject) leaves them untouched.
//   - Frame with frame_err=1 still pulses rx_done_tick and updates dout.
//     The consumer decides whether to discard it.
//   - Back-to-back frames: a new start is accepted on the clk after the STOP->IDLE transition.
//     No extra idle time required beyond the stop bit.
//   - rx held low (break): completes a frame with dout=0, frame_err=1.
//     Then re-enters START immediately and repeats while rx stays low.
//   - Reset mid-frame: immediate abort to IDLE. No pulse. Partial data discarded.
//   - s_tick never asserted: FSM frozen in current state (no timeout).
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     PARITY state inserted after DATA.
//     On s_tick at s==15, sample parity bit and go to STOP, s=0.
//     Even parity: parity_err<=(^shreg)^rx_s, updated together with dout.
//     Frame length grows by one bit.
//   UART_RX_PARITY_EN undefined:
//     No PARITY state; parity_err constant 0; port is still present.
// TESTING (bench: s_tick every 4 clk -> 64 clk per bit; default params unless noted)
//   1. Send 0xA5, stop=1
//      -> single rx_done_tick pulse, dout=0xA5, frame_err=0.
//      Pulse ~9.5 bit times (+2 sync clk) after falling start edge.
//   2. Send 0x3C, then 0xFF, with no idle gap
//      -> two pulses, dout=0x3C then 0xFF, frame_err=0 both.
//   3. Drive rx low for 3 ticks (12 clk), then high
//      -> no rx_done_tick; FSM back in IDLE; dout unchanged.
//   4. Send 0x55 with stop bit forced low
//      -> pulse, dout=0x55, frame_err=1.
//      Then a valid 0x01 -> dout=0x01, frame_err=0.
//   5. Assert reset at data bit 4 of 0x0F, release, then send 0x81
//      -> no pulse for the aborted frame; next pulse dout=0x81.
//   6. UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> parity_err=0.
//      Send 0x07 with parity bit 0 -> parity_err=1.
//      Macro off: parity_err stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver, LSB first, mid-bit sampling, framing/parity flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t state_reg, state_next;

    logic            rx_meta, rx_s;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            ferr_reg, ferr_next;
    logic            done_reg, done_next;

`ifdef UART_RX_PARITY_EN
    logic            pbad_reg, pbad_next;
    logic            perr_reg, perr_next;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            ferr_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            ferr_reg  <= ferr_next;
            done_reg  <= done_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pbad_reg <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            pbad_reg <= pbad_next;
            perr_reg <= perr_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        ferr_next  = ferr_reg;
        done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_next  = pbad_reg;
        perr_next  = perr_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next     = '0;
                        pbad_next  = (^b_reg) ^ rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        // Flags and word commit together; the pulse lines up with them
                        state_next = IDLE;
                        s_next     = '0;
                        dout_next  = b_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = pbad_reg;
`endif
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign frame_err    = ferr_reg;
    assign rx_done_tick = done_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_reg;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
